// File: rtl/nibble_sweep_pkg.sv
// Shared types and constants for the nibble sweep driver and its expected-result FIFO.
package nibble_sweep_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'b00,
        SWEEP = 2'b01,
        DRAIN = 2'b10
    } state_e;

    localparam logic [1:0] SEL_IDLE = 2'b00;
    localparam logic [1:0] SEL_B1   = 2'b01;
    localparam logic [1:0] SEL_B2   = 2'b10;
    localparam logic [1:0] SEL_B3   = 2'b11;

    localparam int NIB_W = 32'd4;
    localparam int RES_W = 32'd5;
    localparam int ACC_W = 32'd7;

    // Reference sum of two nibbles as the calculator should report it.
    function automatic logic [RES_W-1:0] exp_sum(input logic [NIB_W-1:0] a, input logic [NIB_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/nibble_sweep_drv_if.sv
// Upstream nibble stream, calculator operand/result and status signals of the sweep driver.
interface nibble_sweep_drv_if;
    import nibble_sweep_pkg::*;

    logic                 in_valid;
    logic [NIB_W-1:0]     in_nib;
    logic                 in_ready;
    logic [4*NIB_W-1:0]   d_o;
    logic [1:0]           sel_o;
    logic [RES_W-1:0]     res;
    logic                 res_valid;
    logic [ACC_W-1:0]     acc_o;
    logic                 done;
    logic                 err_timeout;
    logic                 err_mismatch;

    modport slave (
        input  in_valid, in_nib, res, res_valid,
        output in_ready, d_o, sel_o, acc_o, done, err_timeout, err_mismatch
    );

    modport master (
        output in_valid, in_nib, res, res_valid,
        input  in_ready, d_o, sel_o, acc_o, done, err_timeout, err_mismatch
    );

endinterface

// File: rtl/nibble_exp_fifo.sv
// Three-entry expected-result FIFO, loaded in one shot and popped per result.
// Present only when NIBBLE_SWEEP_CHECK_EN is defined.
`ifdef NIBBLE_SWEEP_CHECK_EN
module nibble_exp_fifo
    import nibble_sweep_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [RES_W-1:0] e0_i,
    input  logic [RES_W-1:0] e1_i,
    input  logic [RES_W-1:0] e2_i,
    input  logic             pop_i,
    output logic [RES_W-1:0] head_o
);

    logic [RES_W-1:0] mem_q [3];
    logic [1:0]       rd_q;

    // Entry storage and read pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            mem_q[2] <= '0;
            rd_q     <= 2'd0;
        end else if (load_i) begin
            mem_q[0] <= e0_i;
            mem_q[1] <= e1_i;
            mem_q[2] <= e2_i;
            rd_q     <= 2'd0;
        end else if (pop_i && (rd_q != 2'd3)) begin
            rd_q <= rd_q + 2'd1;
        end else begin
            rd_q <= rd_q;
        end
    end

    // Head-of-queue select.
    always_comb begin
        head_o = '0;
        case (rd_q)
            2'd0:    head_o = mem_q[0];
            2'd1:    head_o = mem_q[1];
            2'd2:    head_o = mem_q[2];
            default: head_o = '0;
        endcase
    end

endmodule
`endif

// File: rtl/nibble_sweep_drv.sv
// Assembles four nibbles into a word, sweeps three calculator selects and sums the results.
// Optional result checking against d[3:0]+d[n] is enabled by NIBBLE_SWEEP_CHECK_EN.
module nibble_sweep_drv
    import nibble_sweep_pkg::*;
#(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst,
    nibble_sweep_drv_if.slave bus
);

    localparam int DW = $clog2(TIMEOUT_CYC + 1);

    state_e             state_q, state_d;
    logic [1:0]         fill_q, fill_d;
    logic [1:0]         sweep_q, sweep_d;
    logic [1:0]         rcnt_q, rcnt_d;
    logic [DW-1:0]      drain_q, drain_d;
    logic [4*NIB_W-1:0] d_q, d_d;
    logic [1:0]         sel_q, sel_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               rdy_q, rdy_d;
    logic               done_q, done_d;
    logic               err_to_q, err_to_d;
    logic               accept_s, count_s, last_s;

    // Handshake qualifiers; rdy_q is high exactly in LOAD once out of reset.
    always_comb begin
        accept_s = bus.in_valid && rdy_q;
        count_s  = bus.res_valid && (state_q != LOAD) && (rcnt_q != 2'd3);
        last_s   = count_s && (rcnt_q == 2'd2);
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        sweep_d  = sweep_q;
        rcnt_d   = rcnt_q;
        drain_d  = drain_q;
        d_d      = d_q;
        acc_d    = acc_q;
        done_d   = 1'b0;
        err_to_d = err_to_q;
        if (count_s) begin
            rcnt_d = rcnt_q + 2'd1;
            acc_d  = acc_q + {{(ACC_W-RES_W){1'b0}}, bus.res};
        end else begin
            rcnt_d = rcnt_q;
        end
        case (state_q)
            LOAD: begin
                if (accept_s) begin
                    d_d[{fill_q, 2'b00} +: NIB_W] = bus.in_nib;
                    fill_d = fill_q + 2'd1;
                    if (fill_q == 2'd3) begin
                        state_d = SWEEP;
                        sweep_d = 2'd0;
                        rcnt_d  = 2'd0;
                        acc_d   = '0;
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    fill_d = fill_q;
                end
            end
            SWEEP: begin
                if (last_s) begin
                    state_d = LOAD;
                    done_d  = 1'b1;
                end else if (sweep_q == 2'd2) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    sweep_d = sweep_q + 2'd1;
                end
            end
            DRAIN: begin
                // A completing result wins over a timeout in the same cycle.
                if (last_s) begin
                    state_d = LOAD;
                    done_d  = 1'b1;
                end else if (drain_q == DW'(TIMEOUT_CYC - 1)) begin
                    state_d  = LOAD;
                    err_to_d = 1'b1;
                end else begin
                    drain_d = drain_q + DW'(1'b1);
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // Output decode from the next state so ready/select are registered.
    always_comb begin
        rdy_d = (state_d == LOAD);
        sel_d = SEL_IDLE;
        if (state_d == SWEEP) begin
            case (sweep_d)
                2'd0:    sel_d = SEL_B1;
                2'd1:    sel_d = SEL_B2;
                2'd2:    sel_d = SEL_B3;
                default: sel_d = SEL_IDLE;
            endcase
        end else begin
            sel_d = SEL_IDLE;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= LOAD;
            fill_q   <= 2'd0;
            sweep_q  <= 2'd0;
            rcnt_q   <= 2'd0;
            drain_q  <= '0;
            d_q      <= '0;
            sel_q    <= SEL_IDLE;
            acc_q    <= '0;
            rdy_q    <= 1'b0;
            done_q   <= 1'b0;
            err_to_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            sweep_q  <= sweep_d;
            rcnt_q   <= rcnt_d;
            drain_q  <= drain_d;
            d_q      <= d_d;
            sel_q    <= sel_d;
            acc_q    <= acc_d;
            rdy_q    <= rdy_d;
            done_q   <= done_d;
            err_to_q <= err_to_d;
        end
    end

    assign bus.in_ready    = rdy_q;
    assign bus.d_o         = d_q;
    assign bus.sel_o       = sel_q;
    assign bus.acc_o       = acc_q;
    assign bus.done        = done_q;
    assign bus.err_timeout = err_to_q;

`ifdef NIBBLE_SWEEP_CHECK_EN
    logic             load_exp_s;
    logic [RES_W-1:0] exp_head_s;
    logic             err_mm_q, err_mm_d;

    // Expected sums are taken from the word as it completes, i.e. from d_d.
    always_comb begin
        load_exp_s = accept_s && (fill_q == 2'd3) && (state_q == LOAD);
        err_mm_d   = err_mm_q | (count_s && (bus.res != exp_head_s));
    end

    nibble_exp_fifo u_exp_fifo (
        .clk    (clk),
        .rst    (rst),
        .load_i (load_exp_s),
        .e0_i   (exp_sum(d_d[3:0], d_d[7:4])),
        .e1_i   (exp_sum(d_d[3:0], d_d[11:8])),
        .e2_i   (exp_sum(d_d[3:0], d_d[15:12])),
        .pop_i  (count_s),
        .head_o (exp_head_s)
    );

    // Sticky mismatch flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_mm_q <= 1'b0;
        end else begin
            err_mm_q <= err_mm_d;
        end
    end

    assign bus.err_mismatch = err_mm_q;
`else
    assign bus.err_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_sweep_drv.sv
// Randomized bench for nibble_sweep_drv with a transaction-level reference model.
module tb_nibble_sweep_drv;

    localparam int T = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;

    nibble_sweep_drv_if bus ();

    nibble_sweep_drv #(.TIMEOUT_CYC(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: current word, held accumulator and sticky flags.
    logic [15:0] m_d   = 16'h0;
    logic [6:0]  m_acc = 7'd0;
    bit          m_to  = 1'b0;
    bit          m_mm  = 1'b0;

    // Result pulse plan for one word: cycle offsets from SWEEP entry and values.
    int          p_n;
    int          p_cyc [3];
    logic [4:0]  p_val [3];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] nsum(input logic [15:0] w, input int j);
        logic [3:0] a;
        logic [3:0] b;
        a = w[3:0];
        b = w[4*(j+1) +: 4];
        return 5'(a) + 5'(b);
    endfunction

    task automatic set_plan(input int n, input int c0, input int c1, input int c2,
                            input logic [4:0] v0, input logic [4:0] v1, input logic [4:0] v2);
        p_n = n;
        p_cyc[0] = c0; p_cyc[1] = c1; p_cyc[2] = c2;
        p_val[0] = v0; p_val[1] = v1; p_val[2] = v2;
    endtask

    task automatic load_word(input logic [15:0] w, input int gmin, input int gmax);
        check_eq("load_ready", 32'(bus.in_ready), 32'd1);
        check_eq("load_sel", 32'(bus.sel_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            int g;
            g = int'($urandom_range(gmax, gmin));
            for (int k = 0; k < g; k++) begin
                bus.in_valid  = 1'b0;
                bus.in_nib    = 4'($urandom);
                bus.res_valid = 1'($urandom);
                bus.res       = 5'($urandom);
                tick();
                check_eq("gap_ready", 32'(bus.in_ready), 32'd1);
                check_eq("gap_d", 32'(bus.d_o), 32'(m_d));
                check_eq("gap_acc", 32'(bus.acc_o), 32'(m_acc));
            end
            bus.in_valid  = 1'b1;
            bus.in_nib    = w[4*i +: 4];
            bus.res_valid = 1'($urandom);
            bus.res       = 5'($urandom);
            tick();
            m_d[4*i +: 4] = w[4*i +: 4];
            check_eq("fill_d", 32'(bus.d_o), 32'(m_d));
            check_eq("fill_ready", 32'(bus.in_ready), (i < 3) ? 32'd1 : 32'd0);
            if (i < 3) check_eq("load_acc_hold", 32'(bus.acc_o), 32'(m_acc));
        end
        bus.in_valid  = 1'b0;
        bus.res_valid = 1'b0;
    endtask

    // Starts in SWEEP cycle 0; ends one cycle after the return to LOAD.
    task automatic run_results();
        int         cnt;
        int         endc;
        bit         comp;
        bit         mm;
        logic [6:0] sum;
        cnt = 0; comp = 1'b0; mm = 1'b0; sum = 7'd0; endc = T + 3;
        for (int j = 0; j < p_n; j++) begin
            if (!comp && p_cyc[j] <= T + 2) begin
                if (p_val[j] != nsum(m_d, cnt)) mm = 1'b1;
                sum = sum + 7'(p_val[j]);
                cnt++;
                if (cnt == 3) begin
                    comp = 1'b1;
                    endc = p_cyc[j] + 1;
                end
            end
        end
        for (int k = 0; k < endc; k++) begin
            bit hit;
            logic [4:0] v;
            check_eq("busy_sel", 32'(bus.sel_o), (k < 3) ? 32'(k + 1) : 32'd0);
            check_eq("busy_ready", 32'(bus.in_ready), 32'd0);
            check_eq("busy_d", 32'(bus.d_o), 32'(m_d));
            check_eq("busy_done", 32'(bus.done), 32'd0);
            hit = 1'b0;
            v = 5'($urandom_range(30, 0));
            for (int j = 0; j < p_n; j++) begin
                if (p_cyc[j] == k) begin
                    hit = 1'b1;
                    v = p_val[j];
                end
            end
            bus.res_valid = hit;
            bus.res       = v;
            tick();
        end
        bus.res_valid = 1'b0;
        m_acc = sum;
        if (!comp) m_to = 1'b1;
`ifdef NIBBLE_SWEEP_CHECK_EN
        if (mm) m_mm = 1'b1;
`endif
        check_eq("end_ready", 32'(bus.in_ready), 32'd1);
        check_eq("end_done", 32'(bus.done), 32'(comp));
        check_eq("end_acc", 32'(bus.acc_o), 32'(m_acc));
        check_eq("end_sel", 32'(bus.sel_o), 32'd0);
        check_eq("err_timeout", 32'(bus.err_timeout), 32'(m_to));
        check_eq("err_mismatch", 32'(bus.err_mismatch), 32'(m_mm));
        bus.res_valid = 1'b1;
        bus.res       = 5'd7;
        tick();
        bus.res_valid = 1'b0;
        check_eq("done_pulse", 32'(bus.done), 32'd0);
        check_eq("post_acc", 32'(bus.acc_o), 32'(m_acc));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
        check_eq({tag, "_d"}, 32'(bus.d_o), 32'd0);
        check_eq({tag, "_sel"}, 32'(bus.sel_o), 32'd0);
        check_eq({tag, "_acc"}, 32'(bus.acc_o), 32'd0);
        check_eq({tag, "_done"}, 32'(bus.done), 32'd0);
        check_eq({tag, "_to"}, 32'(bus.err_timeout), 32'd0);
        check_eq({tag, "_mm"}, 32'(bus.err_mismatch), 32'd0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_nib    = 4'h0;
        bus.res_valid = 1'b0;
        bus.res       = 5'd0;
        #12;
        check_reset_outputs("por");
        @(negedge clk);
        rst = 1'b1;
        tick();
        check_eq("por_release_ready", 32'(bus.in_ready), 32'd1);

        // Back-to-back 1,2,3,4 with results 3,4,5.
        load_word(16'h4321, 0, 0);
        set_plan(3, 0, 1, 2, 5'd3, 5'd4, 5'd5);
        run_results();

        // All-F word with two-cycle gaps; maximum accumulation.
        load_word(16'hFFFF, 2, 2);
        set_plan(3, 1, 4, 9, 5'd30, 5'd30, 5'd30);
        run_results();

        // Third result on the last DRAIN cycle completes instead of timing out.
        load_word(16'h2A51, 0, 1);
        set_plan(3, 0, 5, T + 2, nsum(16'h2A51, 0), nsum(16'h2A51, 1), nsum(16'h2A51, 2));
        run_results();

        // Wrong third result.
        load_word(16'h4321, 0, 0);
        set_plan(3, 0, 1, 2, 5'd3, 5'd4, 5'd6);
        run_results();

        // Only two results: timeout.
        load_word(16'h1234, 0, 1);
        set_plan(2, 0, 2, 0, nsum(16'h1234, 0), nsum(16'h1234, 1), 5'd0);
        run_results();

        // Third result one cycle too late is not counted.
        load_word(16'h0F0F, 0, 0);
        set_plan(3, 1, 3, T + 3, nsum(16'h0F0F, 0), nsum(16'h0F0F, 1), nsum(16'h0F0F, 2));
        run_results();

        // Reset during the second SWEEP cycle.
        load_word(16'h9876, 0, 0);
        bus.res_valid = 1'b1;
        bus.res       = 5'd3;
        tick();
        bus.res_valid = 1'b0;
        check_eq("pre_rst_sel", 32'(bus.sel_o), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        m_d = 16'h0; m_acc = 7'd0; m_to = 1'b0; m_mm = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        check_eq("rst_release_ready", 32'(bus.in_ready), 32'd1);
        load_word(16'h4321, 0, 0);
        set_plan(3, 0, 1, 2, 5'd3, 5'd4, 5'd5);
        run_results();

        // Random words and result schedules.
        for (int n = 0; n < 40; n++) begin
            logic [15:0] w;
            int c;
            w = 16'($urandom);
            load_word(w, 0, 2);
            p_n = ($urandom_range(3, 0) == 0) ? int'($urandom_range(2, 0)) : 3;
            c = 0;
            for (int j = 0; j < 3; j++) begin
                p_cyc[j] = c + int'($urandom_range(5, 0));
                c = p_cyc[j] + 1;
                p_val[j] = ($urandom_range(4, 0) == 0) ? 5'($urandom_range(30, 0)) : nsum(w, j);
            end
            run_results();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nibble_sweep_drv.md
NIBBLE_SWEEP_DRV -- requirements
Module: nibble_sweep_drv

Interface
REQ-001 Parameter TIMEOUT_CYC, default 15: maximum DRAIN cycles allowed before err_timeout is raised.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream nibble valid.
REQ-005 in_nib  input  4  upstream nibble data.
REQ-006 in_ready  output  1  high only in LOAD; a nibble is accepted when in_valid && in_ready.
REQ-007 d_o  output  16  assembled word driven to the nibble-sum calculator.
REQ-008 sel_o  output  2  operand select driven to the calculator.
REQ-009 res  input  5  calculator result.
REQ-010 res_valid  input  1  calculator result valid.
REQ-011 acc_o  output  7  sum of the three results for the current word.
REQ-012 done  output  1  one-cycle pulse when a word's three results have been collected.
REQ-013 err_timeout  output  1  sticky flag; set on DRAIN timeout.
REQ-014 err_mismatch  output  1  sticky flag; set on a result mismatch (see Configuration).

Function
REQ-015 The FSM SHALL have states LOAD, SWEEP, DRAIN; it SHALL enter LOAD on reset.
REQ-016 LOAD: in_ready=1, sel_o=00.
  - Accepted nibbles SHALL fill d_o[3:0], [7:4], [11:8], [15:12] in that order (2-bit fill counter).
  - Cycles with in_valid=0 SHALL not advance the counter.
REQ-017 The cycle after the 4th nibble is accepted, the FSM SHALL enter SWEEP.
REQ-018 SWEEP SHALL last exactly 3 cycles.
  - sel_o SHALL be 01, 10, 11 on consecutive cycles.
  - d_o SHALL be held stable for the whole of SWEEP and DRAIN.
  - in_ready=0.
REQ-019 After SWEEP the FSM SHALL enter DRAIN with sel_o=00 and stay there until 3 results have been counted.
REQ-020 Result counting:
  - A 2-bit counter SHALL count res_valid pulses during SWEEP and DRAIN, and SHALL clear on entry to SWEEP.
  - res_valid in LOAD SHALL be ignored.
  - Pulses beyond the 3rd SHALL be ignored.
REQ-021 acc_o SHALL clear on entry to SWEEP, then add zero-extended res on each counted pulse.
  - Maximum is 3*30=90, so no overflow occurs.
  - acc_o SHALL hold its value through LOAD until the next SWEEP.
REQ-022 On the 3rd counted pulse:
  - done SHALL pulse high the following cycle.
  - The FSM SHALL return to LOAD in that same cycle.
  - The fill counter SHALL be zero.
REQ-023 A DRAIN cycle counter SHALL run from DRAIN entry.
  - If it reaches TIMEOUT_CYC without 3 results, err_timeout SHALL set and the FSM SHALL return to LOAD.
  - done SHALL stay low in that case.
REQ-024 err_timeout and err_mismatch SHALL clear only on reset.
REQ-025 A res_valid arriving in the same cycle as the timeout SHALL be counted; if it is the 3rd, completion takes precedence and no timeout is flagged.

Reset
REQ-026 On rst low, asynchronously:
  - State SHALL be LOAD.
  - d_o, sel_o, acc_o, all counters, done and both error flags SHALL be 0.
  - in_ready SHALL be 1 from the first clock after release.
REQ-027 Reset mid-SWEEP or mid-DRAIN SHALL discard the partial word and its results.

Configuration
REQ-028 With macro NIBBLE_SWEEP_CHECK_EN defined, a 3-entry expected-result FIFO SHALL be loaded at SWEEP entry.
  - Entries: d[3:0]+d[7:4], d[3:0]+d[11:8], d[3:0]+d[15:12], each 5 bits.
  - The FIFO SHALL pop in order on each counted res_valid.
  - A mismatch SHALL set err_mismatch.
REQ-029 Without NIBBLE_SWEEP_CHECK_EN, the FIFO and compare logic SHALL be absent and err_mismatch SHALL be tied to 0.

Structure
REQ-030 A shared package nibble_sweep_pkg SHALL hold:
  - the state enum (LOAD/SWEEP/DRAIN);
  - sel constants SEL_IDLE=00, SEL_B1=01, SEL_B2=10, SEL_B3=11;
  - width constants NIB_W=4, RES_W=5, ACC_W=7.
REQ-031 The expected FIFO SHALL be the sub-module nibble_exp_fifo (depth 3, width 5), instantiated only under NIBBLE_SWEEP_CHECK_EN.

Verification
REQ-032 Nibbles 1,2,3,4 back-to-back -> d_o=0x4321, sel_o 01/10/11 over 3 cycles; results 3,4,5 -> acc_o=12, done pulses once, in_ready=1 the next cycle.
REQ-033 Nibbles F,F,F,F with in_valid gaps of 2 cycles -> d_o=0xFFFF only after the 4th acceptance; results 30,30,30 -> acc_o=90.
REQ-034 Only 2 results returned -> err_timeout=1 after TIMEOUT_CYC DRAIN cycles, done stays 0, FSM returns to LOAD.
REQ-035 rst low during the 2nd SWEEP cycle -> all outputs 0 immediately; the next 4 nibbles form a fresh word.
REQ-036 With NIBBLE_SWEEP_CHECK_EN, d=0x4321 and results 3,4,6 -> err_mismatch=1 after the 3rd result; with correct results 3,4,5 it stays 0.
